// File: rtl/pc_sequencer.sv
// In-order PC sequencer: fetch over req/ack, issue over valid/ready,
// then wait for branch resolution before choosing the next PC.
module pc_sequencer #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               resolve_valid,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic [31:0]        retired,
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    RESOLVE,
    HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (imem_ack)      state_d = ISSUE;
      ISSUE:   if (instr_ready)   state_d = RESOLVE;
      RESOLVE: if (resolve_valid) state_d = halt ? HALTED : FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      FETCH:   imem_req    = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      RESOLVE: ;
      HALTED:  halted      = 1'b1;
      default: ;
    endcase
  end

  // Halt wins over branch; the PC of a halting instruction is kept.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    if (state_q == FETCH && imem_ack) begin
      instr_d = imem_rdata;
    end
    if (state_q == RESOLVE && resolve_valid) begin
      retired_d = retired_q + 32'd1;
      if (!halt) begin
        pc_d = branch ? {branch_target[ADDR_W-1:2], 2'b00}
                      : pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;

endmodule
